// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68K bus target: register offsets, FSM states
// and the status word layout.
package m68k_bus_pkg;

   localparam logic [1:0] OFS_DATA    = 2'd0;
   localparam logic [1:0] OFS_STATUS  = 2'd1;
   localparam logic [1:0] OFS_SCRATCH = 2'd2;
   localparam logic [1:0] OFS_ID      = 2'd3;

   typedef enum logic [1:0] {IDLE, WAIT, ACK, REL} state_e;

   localparam int ST_OVERFLOW   = 15;
   localparam int ST_INBOX_FULL = 14;
   localparam int ST_FIFO_FULL  = 13;
   localparam int ST_FIFO_EMPTY = 12;

   function automatic logic [15:0] pack_status(input logic       ovf,
                                               input logic       inbox_full,
                                               input logic       fifo_full,
                                               input logic       fifo_empty,
                                               input logic [3:0] count);
      logic [15:0] s;
      s                = '0;
      s[ST_OVERFLOW]   = ovf;
      s[ST_INBOX_FULL] = inbox_full;
      s[ST_FIFO_FULL]  = fifo_full;
      s[ST_FIFO_EMPTY] = fifo_empty;
      s[3:0]           = count;
      return s;
   endfunction

endpackage

// File: rtl/m68k_bus_target_if.sv
// 68K bus pins shared by the bus initiator (master side) and this target.
interface m68k_bus_target_if;
   import m68k_bus_pkg::*;

   logic [23:1] m68k_a;
   logic [15:0] m68k_d_in;
   logic [15:0] m68k_d_out;
   logic        m68k_d_oe;
   logic        m68k_as_n;
   logic        m68k_uds_n;
   logic        m68k_lds_n;
   logic        m68k_rw;
   logic        m68k_dtack_n;
   logic        m68k_dtack_oe;

   modport master (
      output m68k_a, m68k_d_in, m68k_as_n, m68k_uds_n, m68k_lds_n, m68k_rw,
      input  m68k_d_out, m68k_d_oe, m68k_dtack_n, m68k_dtack_oe
   );

   modport slave (
      input  m68k_a, m68k_d_in, m68k_as_n, m68k_uds_n, m68k_lds_n, m68k_rw,
      output m68k_d_out, m68k_d_oe, m68k_dtack_n, m68k_dtack_oe
   );

endinterface

// File: rtl/m68k_target_fifo.sv
// 68K-to-Pi word FIFO; pushes into a full FIFO are dropped and flagged sticky.
module m68k_target_fifo
   import m68k_bus_pkg::*;
#(
   parameter int unsigned DW = 16,
   parameter int unsigned AW = 2
) (
   input  logic          c7m,
   input  logic          op_reqrst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   input  logic          clr_overflow,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow
);

   logic [DW-1:0] mem [2**AW];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          do_push, do_pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == (AW+1)'(2**AW));
   assign count    = count_q;
   assign overflow = ovf_q;
   assign rdata    = mem[rd_ptr_q];

   // A pop frees the slot in the same cycle, so push+pop on a full FIFO is accepted.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      // NOTE: every comb output gets a default first so no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
      if (push && !do_push) ovf_d = 1'b1;
      else if (clr_overflow) ovf_d = 1'b0;
   end

   // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
   always_ff @(posedge c7m or posedge op_reqrst) begin
      if (op_reqrst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // NOTE: storage is not reset; count/pointers alone define which words are valid.
   always_ff @(posedge c7m) begin
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/m68k_bus_target.sv
// 68K bus responder: decodes a 16-byte window, answers with DTACK and bridges
// words to the Pi through a FIFO (68K->Pi) and an inbox register (Pi->68K).
module m68k_bus_target
   import m68k_bus_pkg::*;
#(
   parameter logic [19:0] BASE_A          = 20'hEE000,
   parameter int unsigned WAIT_STATES     = 1,
   parameter int unsigned FIFO_DEPTH_LOG2 = 2,
   parameter logic [15:0] ID_WORD         = 16'hC0DE
) (
   input  logic                    c7m,
   input  logic                    op_reqrst,
   m68k_bus_target_if.slave        bus,
   input  logic                    pi_pop,
   output logic [15:0]             pi_rdata,
   output logic                    pi_empty,
   input  logic                    pi_inbox_wr,
   input  logic [15:0]             pi_inbox_data,
   output logic                    pi_inbox_full
);

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        as_q, uds_q, lds_q, rw_q;
   logic [23:1] a_q;
   logic        dtack_oe_q, dtack_oe_d, dtack_n_q, dtack_n_d;
   logic        d_oe_q, d_oe_d;
   logic [15:0] d_out_q, d_out_d;
   logic        access_q, access_d;
   logic [15:0] scratch_q, scratch_d;
   logic [15:0] inbox_data_q, inbox_data_d;
   logic        inbox_full_q, inbox_full_d;

   logic        hit, ds_any, acc_rd, acc_wr, fifo_push, clr_ovf;
   logic        fifo_full, fifo_ovf;
   logic [FIFO_DEPTH_LOG2:0] fifo_count;
   logic [1:0]  ofs;
   logic [15:0] rd_word;
   logic        unused_a3;

   assign unused_a3 = a_q[3];
   assign hit       = !as_q && (a_q[23:4] == BASE_A);
   assign ofs       = a_q[2:1];
   assign ds_any    = !uds_q || !lds_q;
   assign acc_rd    = access_q && rw_q;
   assign acc_wr    = access_q && !rw_q;
   assign fifo_push = acc_wr && (ofs == OFS_DATA);
   assign clr_ovf   = acc_rd && (ofs == OFS_STATUS);

   m68k_target_fifo #(.DW(16), .AW(FIFO_DEPTH_LOG2)) u_fifo (
      .c7m          (c7m),
      .op_reqrst    (op_reqrst),
      .push         (fifo_push),
      .push_data    (bus.m68k_d_in),
      .pop          (pi_pop),
      .clr_overflow (clr_ovf),
      .rdata        (pi_rdata),
      .full         (fifo_full),
      .empty        (pi_empty),
      .count        (fifo_count),
      .overflow     (fifo_ovf)
   );

   always_comb begin
      rd_word = ID_WORD;
      unique case (ofs)
         OFS_DATA:    rd_word = inbox_data_q;
         OFS_STATUS:  rd_word = pack_status(fifo_ovf, inbox_full_q, fifo_full,
                                            pi_empty, 4'(fifo_count));
         OFS_SCRATCH: rd_word = scratch_q;
         OFS_ID:      rd_word = ID_WORD;
      endcase
   end

   // Bus FSM; outputs are computed for the next state so they leave flops.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dtack_oe_d = dtack_oe_q;
      dtack_n_d  = dtack_n_q;
      d_oe_d     = d_oe_q;
      d_out_d    = d_out_q;
      access_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            dtack_oe_d = 1'b0;
            dtack_n_d  = 1'b1;
            d_oe_d     = 1'b0;
            if (hit) begin
               state_d = WAIT;
               cnt_d   = 3'(WAIT_STATES);
               d_oe_d  = rw_q;
               d_out_d = rd_word;
            end
         end
         WAIT: begin
            if (as_q) begin
               state_d = IDLE;
               d_oe_d  = 1'b0;
            end else begin
               d_out_d = rd_word;
               if (cnt_q != 3'd0) begin
                  cnt_d = cnt_q - 3'd1;
               end else if (rw_q || ds_any) begin
                  state_d    = ACK;
                  dtack_oe_d = 1'b1;
                  dtack_n_d  = 1'b0;
                  access_d   = 1'b1;
               end
            end
         end
         ACK: begin
            if (as_q) begin
               state_d   = REL;
               dtack_n_d = 1'b1;
               d_oe_d    = 1'b0;
            end
         end
         REL: begin
            state_d    = IDLE;
            dtack_oe_d = 1'b0;
            dtack_n_d  = 1'b1;
         end
      endcase
   end

   // Access side effects land on the first ACK cycle (access_q); Pi writes beat 68K clears.
   always_comb begin
      scratch_d    = scratch_q;
      inbox_data_d = inbox_data_q;
      inbox_full_d = inbox_full_q;
      if (acc_wr && (ofs == OFS_SCRATCH)) begin
         if (!uds_q) scratch_d[15:8] = bus.m68k_d_in[15:8];
         if (!lds_q) scratch_d[7:0]  = bus.m68k_d_in[7:0];
      end
      if (pi_inbox_wr) begin
         inbox_data_d = pi_inbox_data;
         inbox_full_d = 1'b1;
      end else if (acc_rd && (ofs == OFS_DATA)) begin
         inbox_full_d = 1'b0;
      end
   end

   always_ff @(posedge c7m or posedge op_reqrst) begin
      if (op_reqrst) begin
         as_q         <= 1'b1;
         uds_q        <= 1'b1;
         lds_q        <= 1'b1;
         rw_q         <= 1'b1;
         a_q          <= '0;
         state_q      <= IDLE;
         cnt_q        <= '0;
         dtack_oe_q   <= 1'b0;
         dtack_n_q    <= 1'b1;
         d_oe_q       <= 1'b0;
         d_out_q      <= '0;
         access_q     <= 1'b0;
         scratch_q    <= '0;
         inbox_data_q <= '0;
         inbox_full_q <= 1'b0;
      end else begin
         as_q         <= bus.m68k_as_n;
         uds_q        <= bus.m68k_uds_n;
         lds_q        <= bus.m68k_lds_n;
         rw_q         <= bus.m68k_rw;
         a_q          <= bus.m68k_a;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dtack_oe_q   <= dtack_oe_d;
         dtack_n_q    <= dtack_n_d;
         d_oe_q       <= d_oe_d;
         d_out_q      <= d_out_d;
         access_q     <= access_d;
         scratch_q    <= scratch_d;
         inbox_data_q <= inbox_data_d;
         inbox_full_q <= inbox_full_d;
      end
   end

   assign bus.m68k_dtack_oe = dtack_oe_q;
   assign bus.m68k_dtack_n  = dtack_n_q;
   assign bus.m68k_d_oe     = d_oe_q;
   assign bus.m68k_d_out    = d_out_q;
   assign pi_inbox_full     = inbox_full_q;

endmodule

// File: tb/tb_m68k_bus_target.sv
// Directed bench for m68k_bus_target: a WAIT_STATES=1 unit does the main work,
// a WAIT_STATES=3 unit on the same bus exercises aborted cycles.
module tb_m68k_bus_target;

   localparam int          W1   = 1;
   localparam int          W3   = 3;
   localparam logic [19:0] BASE = 20'hEE000;

   logic        c7m = 1'b0;
   logic        op_reqrst;
   logic [23:1] a;
   logic [15:0] d_in;
   logic        as_n, uds_n, lds_n, rw;
   logic        pi_pop, pi_inbox_wr;
   logic [15:0] pi_inbox_data;
   logic [15:0] pi_rdata, pi_rdata3;
   logic        pi_empty, pi_empty3, pi_inbox_full, pi_inbox_full3;

   int checks = 0;
   int errors = 0;
   int oe1_cnt = 0;
   int oe3_cnt = 0;

   m68k_bus_target_if b1 ();
   m68k_bus_target_if b3 ();

   assign b1.m68k_a = a;      assign b3.m68k_a = a;
   assign b1.m68k_d_in = d_in; assign b3.m68k_d_in = d_in;
   assign b1.m68k_as_n = as_n; assign b3.m68k_as_n = as_n;
   assign b1.m68k_uds_n = uds_n; assign b3.m68k_uds_n = uds_n;
   assign b1.m68k_lds_n = lds_n; assign b3.m68k_lds_n = lds_n;
   assign b1.m68k_rw = rw;    assign b3.m68k_rw = rw;

   m68k_bus_target #(.WAIT_STATES(W1)) dut (
      .c7m           (c7m),
      .op_reqrst     (op_reqrst),
      .bus           (b1),
      .pi_pop        (pi_pop),
      .pi_rdata      (pi_rdata),
      .pi_empty      (pi_empty),
      .pi_inbox_wr   (pi_inbox_wr),
      .pi_inbox_data (pi_inbox_data),
      .pi_inbox_full (pi_inbox_full)
   );

   m68k_bus_target #(.WAIT_STATES(W3)) dut3 (
      .c7m           (c7m),
      .op_reqrst     (op_reqrst),
      .bus           (b3),
      .pi_pop        (1'b0),
      .pi_rdata      (pi_rdata3),
      .pi_empty      (pi_empty3),
      .pi_inbox_wr   (1'b0),
      .pi_inbox_data (16'h0000),
      .pi_inbox_full (pi_inbox_full3)
   );

   always #5 c7m = ~c7m;

   always @(posedge c7m) begin
      if (b1.m68k_dtack_oe) oe1_cnt++;
      if (b3.m68k_dtack_oe) oe3_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [3:0]  off;
      logic        rw;
      logic        uds_n;
      logic        lds_n;
      logic [15:0] wdata;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [23:1] addr_of(input logic [19:0] base, input logic [3:0] off);
      return {base, off[3:1]};
   endfunction

   // One 68K cycle; waits (bounded) for DTACK from unit `which`, then releases AS.
   task automatic bus_cycle(input logic [23:1] addr, input logic rw_i,
                            input logic uds_i, input logic lds_i,
                            input logic [15:0] wdata, input int which,
                            input bit pop_at_ack, input bit inbox_at_ack,
                            input logic [15:0] inbox_val,
                            output int lat, output logic [15:0] rdata,
                            output logic doe);
      bit acked;
      acked = 1'b0;
      lat   = -1;
      rdata = '0;
      doe   = 1'b0;
      a     = addr;
      rw    = rw_i;
      d_in  = wdata;
      as_n  = 1'b0;
      uds_n = uds_i;
      lds_n = lds_i;
      for (int n = 1; n <= 16 && !acked; n++) begin
         @(negedge c7m);
         if (which == 3 ? (b3.m68k_dtack_oe && !b3.m68k_dtack_n)
                        : (b1.m68k_dtack_oe && !b1.m68k_dtack_n)) begin
            acked = 1'b1;
            lat   = n - 1;
            rdata = (which == 3) ? b3.m68k_d_out : b1.m68k_d_out;
            doe   = (which == 3) ? b3.m68k_d_oe : b1.m68k_d_oe;
         end
      end
      if (acked) begin
         pi_pop = pop_at_ack;
         if (inbox_at_ack) begin
            pi_inbox_wr   = 1'b1;
            pi_inbox_data = inbox_val;
         end
      end
      as_n  = 1'b1;
      uds_n = 1'b1;
      lds_n = 1'b1;
      @(negedge c7m);
      pi_pop      = 1'b0;
      pi_inbox_wr = 1'b0;
      @(negedge c7m);
      if (acked && which == 1) begin
         check("rel_dtack_oe", 32'(b1.m68k_dtack_oe), 32'd1);
         check("rel_dtack_n", 32'(b1.m68k_dtack_n), 32'd1);
      end
      @(negedge c7m);
      if (acked && which == 1) check("idle_dtack_oe", 32'(b1.m68k_dtack_oe), 32'd0);
      @(negedge c7m);
   endtask

   task automatic pop_expect(input string name, input logic [15:0] exp);
      check({name, "_empty"}, 32'(pi_empty), 32'd0);
      check({name, "_rdata"}, 32'(pi_rdata), 32'(exp));
      pi_pop = 1'b1;
      @(negedge c7m);
      pi_pop = 1'b0;
   endtask

   initial begin : main
      int          lat;
      logic [15:0] rd;
      logic        doe;
      int          snap;
      logic [15:0] w;

      op_reqrst = 1'b1;
      a = '0; d_in = '0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
      pi_pop = 1'b0; pi_inbox_wr = 1'b0; pi_inbox_data = '0;

      vecs[0]  = '{4'h4, 1'b0, 1'b0, 1'b0, 16'h1100, 16'h0000};
      vecs[1]  = '{4'h4, 1'b0, 1'b1, 1'b0, 16'hFF77, 16'h0000};
      vecs[2]  = '{4'h4, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1177};
      vecs[3]  = '{4'h6, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hC0DE};
      vecs[4]  = '{4'hE, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hC0DE};
      vecs[5]  = '{4'h4, 1'b0, 1'b0, 1'b1, 16'h5AFF, 16'h0000};
      vecs[6]  = '{4'h4, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h5A77};
      vecs[7]  = '{4'h6, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
      vecs[8]  = '{4'h6, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hC0DE};
      vecs[9]  = '{4'h2, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000};
      vecs[10] = '{4'h2, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1000};
      vecs[11] = '{4'h0, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0000};
      vecs[12] = '{4'h0, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h0000};
      vecs[13] = '{4'h0, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000};
      vecs[14] = '{4'h0, 1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000};
      vecs[15] = '{4'h0, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000};
      vecs[16] = '{4'h2, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hA004};
      vecs[17] = '{4'h2, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h2004};

      repeat (2) @(negedge c7m);
      check("rst_dtack_oe", 32'(b1.m68k_dtack_oe), 32'd0);
      check("rst_dtack_n", 32'(b1.m68k_dtack_n), 32'd1);
      check("rst_d_oe", 32'(b1.m68k_d_oe), 32'd0);
      check("rst_d_out", 32'(b1.m68k_d_out), 32'd0);
      check("rst_pi_empty", 32'(pi_empty), 32'd1);
      check("rst_inbox_full", 32'(pi_inbox_full), 32'd0);
      op_reqrst = 1'b0;
      repeat (2) @(negedge c7m);

      // Word write into the FIFO, then drained by the Pi.
      bus_cycle(addr_of(BASE, 4'h0), 1'b0, 1'b0, 1'b0, 16'h1234, 1, 1'b0, 1'b0, 16'h0,
                lat, rd, doe);
      check("push_latency", 32'(lat), 32'(W1 + 2));
      check("push_d_oe", 32'(doe), 32'd0);
      pop_expect("push_head", 16'h1234);
      check("pop_empty", 32'(pi_empty), 32'd1);

      for (int i = 0; i < 18; i++) begin
         bus_cycle(addr_of(BASE, vecs[i].off), vecs[i].rw, vecs[i].uds_n, vecs[i].lds_n,
                   vecs[i].wdata, 1, 1'b0, 1'b0, 16'h0, lat, rd, doe);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(W1 + 2));
         check($sformatf("vec%0d_d_oe", i), 32'(doe), 32'(vecs[i].rw));
         if (vecs[i].rw) check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp));
      end

      // Overflow dropped the fifth word; first four remain in order.
      for (int i = 1; i <= 4; i++) pop_expect($sformatf("ovf_pop%0d", i), 16'(i));
      check("ovf_drained", 32'(pi_empty), 32'd1);

      // Push into a full FIFO while the Pi pops in the same cycle.
      for (int i = 0; i < 4; i++) begin
         w = 16'h000A + 16'(i);
         bus_cycle(addr_of(BASE, 4'h0), 1'b0, 1'b0, 1'b0, w, 1, 1'b0, 1'b0, 16'h0,
                   lat, rd, doe);
      end
      bus_cycle(addr_of(BASE, 4'h0), 1'b0, 1'b0, 1'b0, 16'h000E, 1, 1'b1, 1'b0, 16'h0,
                lat, rd, doe);
      check("fullpp_latency", 32'(lat), 32'(W1 + 2));
      bus_cycle(addr_of(BASE, 4'h2), 1'b1, 1'b0, 1'b0, 16'h0, 1, 1'b0, 1'b0, 16'h0,
                lat, rd, doe);
      check("fullpp_status", 32'(rd), 32'h2004);
      for (int i = 0; i < 4; i++) pop_expect($sformatf("fullpp_pop%0d", i), 16'h000B + 16'(i));
      check("fullpp_drained", 32'(pi_empty), 32'd1);

      // Inbox: Pi write, 68K read-clear, and write winning over a same-cycle clear.
      pi_inbox_wr = 1'b1; pi_inbox_data = 16'hA5A5;
      @(negedge c7m);
      pi_inbox_wr = 1'b0;
      check("inbox_set", 32'(pi_inbox_full), 32'd1);
      bus_cycle(addr_of(BASE, 4'h0), 1'b1, 1'b0, 1'b0, 16'h0, 1, 1'b0, 1'b0, 16'h0,
                lat, rd, doe);
      check("inbox_rdata", 32'(rd), 32'hA5A5);
      check("inbox_cleared", 32'(pi_inbox_full), 32'd0);
      pi_inbox_wr = 1'b1; pi_inbox_data = 16'h1111;
      @(negedge c7m);
      pi_inbox_wr = 1'b0;
      bus_cycle(addr_of(BASE, 4'h0), 1'b1, 1'b0, 1'b0, 16'h0, 1, 1'b0, 1'b1, 16'h2222,
                lat, rd, doe);
      check("inbox_race_rdata", 32'(rd), 32'h1111);
      check("inbox_race_full", 32'(pi_inbox_full), 32'd1);
      bus_cycle(addr_of(BASE, 4'h0), 1'b1, 1'b0, 1'b0, 16'h0, 1, 1'b0, 1'b0, 16'h0,
                lat, rd, doe);
      check("inbox_new_rdata", 32'(rd), 32'h2222);
      check("inbox_final_full", 32'(pi_inbox_full), 32'd0);

      // WAIT_STATES=3 unit sees AS drop mid-WAIT on a write: no DTACK, no push.
      snap = oe3_cnt;
      bus_cycle(addr_of(BASE, 4'h0), 1'b0, 1'b0, 1'b0, 16'hBEEF, 1, 1'b0, 1'b0, 16'h0,
                lat, rd, doe);
      check("abort_no_dtack", 32'(oe3_cnt - snap), 32'd0);
      check("abort_no_push", 32'(pi_empty3), 32'd1);
      pop_expect("abort_dut1_head", 16'hBEEF);
      bus_cycle(addr_of(BASE, 4'h6), 1'b1, 1'b0, 1'b0, 16'h0, 3, 1'b0, 1'b0, 16'h0,
                lat, rd, doe);
      check("w3_latency", 32'(lat), 32'(W3 + 2));
      check("w3_rdata", 32'(rd), 32'hC0DE);

      // Address outside the window is never acknowledged.
      snap = oe1_cnt;
      bus_cycle(addr_of(BASE + 20'd1, 4'h0), 1'b1, 1'b0, 1'b0, 16'h0, 1, 1'b0, 1'b0, 16'h0,
                lat, rd, doe);
      check("miss_no_ack", 32'(lat), 32'hFFFF_FFFF);
      check("miss_no_oe", 32'(oe1_cnt - snap), 32'd0);

      // Reset in the middle of ACK, with a word queued in the FIFO.
      bus_cycle(addr_of(BASE, 4'h0), 1'b0, 1'b0, 1'b0, 16'h7777, 1, 1'b0, 1'b0, 16'h0,
                lat, rd, doe);
      check("prerst_queued", 32'(pi_empty), 32'd0);
      a = addr_of(BASE, 4'h6); rw = 1'b1; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
      lat = -1;
      for (int n = 1; n <= 16 && lat < 0; n++) begin
         @(negedge c7m);
         if (b1.m68k_dtack_oe && !b1.m68k_dtack_n) lat = n - 1;
      end
      check("midack_reached", 32'(lat), 32'(W1 + 2));
      op_reqrst = 1'b1;
      #1;
      check("midack_dtack_oe", 32'(b1.m68k_dtack_oe), 32'd0);
      check("midack_d_oe", 32'(b1.m68k_d_oe), 32'd0);
      check("midack_pi_empty", 32'(pi_empty), 32'd1);
      as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
      @(negedge c7m);
      op_reqrst = 1'b0;
      repeat (2) @(negedge c7m);
      bus_cycle(addr_of(BASE, 4'h2), 1'b1, 1'b0, 1'b0, 16'h0, 1, 1'b0, 1'b0, 16'h0,
                lat, rd, doe);
      check("postrst_status", 32'(rd), 32'h1000);
      bus_cycle(addr_of(BASE, 4'h4), 1'b1, 1'b0, 1'b0, 16'h0, 1, 1'b0, 1'b0, 16'h0,
                lat, rd, doe);
      check("postrst_scratch", 32'(rd), 32'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
